buzz_ctrl: RTL and testbench

// - Responder side of the Core buzz handshake: on a request from Core (en_buzz), plays a

---
 rtl/buzz_ctrl_pkg.sv | 12 +
 rtl/buzz_ctrl_tone_gen.sv | 35 +++
 rtl/buzz_ctrl.sv | 97 +++++++++
 tb/tb_buzz_ctrl.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/buzz_ctrl_pkg.sv
// Shared state encodings and widths for the buzz responder.
// The state values are fixed because other blocks and benches decode them.
package buzz_ctrl_pkg;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] ST_TONE = 2'd1;
  localparam logic [STATE_W-1:0] ST_GAP  = 2'd2;
  localparam logic [STATE_W-1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/buzz_ctrl_tone_gen.sv
// Square-wave divider for the piezo tone. Held cleared while en is low,
// so every burst begins with a high half period on the first enabled cycle.
module tone_gen #(
  parameter int TONE_HALF_CYC = 25000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic out
);

  localparam int CW = $clog2(TONE_HALF_CYC + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(TONE_HALF_CYC - 1);

  logic [CW-1:0] cnt;
  logic          active;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt    <= '0;
      active <= 1'b0;
      out    <= 1'b0;
    end else if (!active) begin
      active <= 1'b1;
      out    <= 1'b1;
      cnt    <= '0;
    end else if (cnt == HALF_LAST) begin
      cnt <= '0;
      out <= ~out;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/buzz_ctrl.sv
// Buzz responder: plays BEEP_COUNT tone bursts on the piezo per request.
// Optional BUZZ_ABORT_EN: dropping en_buzz during TONE/GAP aborts without a pulse.
module buzz_ctrl
  import buzz_ctrl_pkg::*;
#(
  parameter int TONE_HALF_CYC = 25000,
  parameter int BEEP_ON_CYC   = 5000000,
  parameter int BEEP_OFF_CYC  = 2500000,
  parameter int BEEP_COUNT    = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en_buzz,
  output logic buzz_finished,
  output logic busy,
  output logic buzzer
);

  // Handshake: a rising edge of en_buzz while idle starts a pattern; busy is
  // high until the pattern ends, and buzz_finished pulses once in the DONE cycle.
  localparam int ON_W  = $clog2(BEEP_ON_CYC + 1);
  localparam int OFF_W = $clog2(BEEP_OFF_CYC + 1);
  localparam int IDX_W = $clog2(BEEP_COUNT + 1);

  localparam logic [ON_W-1:0]  ON_LAST  = ON_W'(BEEP_ON_CYC - 1);
  localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(BEEP_OFF_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BEEP_COUNT - 1);

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_nx;
  logic               en_prev;
  logic [ON_W-1:0]    on_cnt;
  logic [OFF_W-1:0]   off_cnt;
  logic [IDX_W-1:0]   idx;
  logic               rise;
  logic               tone_en;

  assign rise    = en_buzz & ~en_prev;
  assign tone_en = (state_nx == ST_TONE);

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (rise) state_nx = ST_TONE;
      end
      ST_TONE: begin
        if (on_cnt == ON_LAST) state_nx = (idx == IDX_LAST) ? ST_DONE : ST_GAP;
`ifdef BUZZ_ABORT_EN
        if (!en_buzz) state_nx = ST_IDLE;
`endif
      end
      ST_GAP: begin
        if (off_cnt == OFF_LAST) state_nx = ST_TONE;
`ifdef BUZZ_ABORT_EN
        if (!en_buzz) state_nx = ST_IDLE;
`endif
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Duration counters restart on every state entry, so a phase never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      en_prev       <= 1'b0;
      on_cnt        <= '0;
      off_cnt       <= '0;
      idx           <= '0;
      busy          <= 1'b0;
      buzz_finished <= 1'b0;
    end else begin
      state         <= state_nx;
      en_prev       <= en_buzz;
      on_cnt        <= (state == ST_TONE && state_nx == ST_TONE) ? on_cnt + ON_W'(1) : '0;
      off_cnt       <= (state == ST_GAP && state_nx == ST_GAP) ? off_cnt + OFF_W'(1) : '0;
      busy          <= (state_nx != ST_IDLE);
      buzz_finished <= (state_nx == ST_DONE);
      if (state_nx == ST_IDLE)
        idx <= '0;
      else if (state == ST_GAP && state_nx == ST_TONE)
        idx <= idx + IDX_W'(1);
    end
  end

  tone_gen #(
    .TONE_HALF_CYC(TONE_HALF_CYC)
  ) u_tone (
    .clk(clk),
    .rst(rst),
    .en (tone_en),
    .out(buzzer)
  );

endmodule

// File: tb/tb_buzz_ctrl.sv
// Bench for buzz_ctrl: two instances (two beeps and one beep) driven by directed
// and random en_buzz/rst sequences, checked every cycle against a timeline model.
module tb_buzz_ctrl;

  localparam int HALF = 2;
  localparam int ON   = 8;
  localparam int OFF  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en0 = 1'b0;
  logic en1 = 1'b0;
  logic fin0, busy0, bz0;
  logic fin1, busy1, bz1;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int   m_start [2];
  logic m_prev  [2];
  int   m_beeps [2];
  int   exp_pulses [2];
  int   obs_pulses [2];

  always #5 clk = ~clk;

  buzz_ctrl #(.TONE_HALF_CYC(HALF), .BEEP_ON_CYC(ON), .BEEP_OFF_CYC(OFF), .BEEP_COUNT(2)) dut0 (
    .clk(clk), .rst(rst), .en_buzz(en0),
    .buzz_finished(fin0), .busy(busy0), .buzzer(bz0)
  );

  buzz_ctrl #(.TONE_HALF_CYC(HALF), .BEEP_ON_CYC(ON), .BEEP_OFF_CYC(OFF), .BEEP_COUNT(1)) dut1 (
    .clk(clk), .rst(rst), .en_buzz(en1),
    .buzz_finished(fin1), .busy(busy1), .buzzer(bz1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  function automatic int total_len(input int beeps);
    return beeps * ON + (beeps - 1) * OFF;
  endfunction

  // Model: a pattern is just its start cycle; outputs follow from the offset.
  task automatic model_update(input int i, input int c, input logic r, input logic e);
    int k;
    if (r) begin
      m_start[i] = -1;
      m_prev[i]  = 1'b0;
      return;
    end
    if (m_start[i] < 0) begin
      if (e && !m_prev[i]) m_start[i] = c;
    end else begin
      k = c - m_start[i] - 1;
      if (k == total_len(m_beeps[i])) m_start[i] = -1;
`ifdef BUZZ_ABORT_EN
      else if (!e) m_start[i] = -1;
`endif
    end
    m_prev[i] = e;
  endtask

  task automatic model_out(input int i, input int c, output logic b, output logic bsy, output logic fin);
    int k, r;
    b = 1'b0; bsy = 1'b0; fin = 1'b0;
    if (m_start[i] >= 0) begin
      k = c - m_start[i] - 1;
      bsy = 1'b1;
      if (k == total_len(m_beeps[i])) begin
        fin = 1'b1;
      end else begin
        r = k % (ON + OFF);
        if (r < ON) b = ((r / HALF) % 2) == 0;
      end
    end
  endtask

  task automatic step(input logic r, input logic e0, input logic e1);
    logic b, bsy, fin;
    @(negedge clk);
    rst = r; en0 = e0; en1 = e1;
    @(posedge clk);
    model_update(0, cyc, r, e0);
    model_update(1, cyc, r, e1);
    cyc++;
    #1;
    model_out(0, cyc, b, bsy, fin);
    if (fin) exp_pulses[0]++;
    if (fin0 === 1'b1) obs_pulses[0]++;
    check("dut0_buzzer", {31'd0, bz0}, {31'd0, b});
    check("dut0_busy", {31'd0, busy0}, {31'd0, bsy});
    check("dut0_finished", {31'd0, fin0}, {31'd0, fin});
    model_out(1, cyc, b, bsy, fin);
    if (fin) exp_pulses[1]++;
    if (fin1 === 1'b1) obs_pulses[1]++;
    check("dut1_buzzer", {31'd0, bz1}, {31'd0, b});
    check("dut1_busy", {31'd0, busy1}, {31'd0, bsy});
    check("dut1_finished", {31'd0, fin1}, {31'd0, fin});
  endtask

  task automatic hold(input logic r, input logic e, input int n);
    for (int j = 0; j < n; j++) step(r, e, e);
  endtask

  initial begin
    int len;
    logic e0, e1;
    m_beeps[0] = 2; m_beeps[1] = 1;
    for (int i = 0; i < 2; i++) begin
      m_start[i] = -1; m_prev[i] = 1'b0;
      exp_pulses[i] = 0; obs_pulses[i] = 0;
    end

    hold(1'b1, 1'b0, 3);

    // Full pattern, then en_buzz held high long after completion.
    hold(1'b0, 1'b0, 2);
    hold(1'b0, 1'b1, 65);

    // Second rising edge at N+5 after a one-cycle low.
    hold(1'b0, 1'b0, 3);
    hold(1'b0, 1'b1, 4);
    hold(1'b0, 1'b0, 1);
    hold(1'b0, 1'b1, 25);

    // Reset mid-pattern at N+10, then a fresh request.
    hold(1'b0, 1'b0, 2);
    hold(1'b0, 1'b1, 10);
    hold(1'b1, 1'b1, 1);
    hold(1'b0, 1'b0, 2);
    hold(1'b0, 1'b1, 30);

    // Request dropped at N+6.
    hold(1'b0, 1'b0, 2);
    hold(1'b0, 1'b1, 6);
    hold(1'b0, 1'b0, 30);

    // Reset released with en_buzz already high starts a pattern.
    hold(1'b1, 1'b1, 2);
    hold(1'b0, 1'b1, 25);

    // Random request levels with occasional resets.
    e0 = 1'b0; e1 = 1'b0;
    for (int n = 0; n < 60; n++) begin
      len = $urandom_range(1, 30);
      e0 = ~e0;
      if ($urandom_range(0, 1) == 1) e1 = ~e1;
      for (int j = 0; j < len; j++)
        step(($urandom_range(0, 60) == 0), e0, e1);
    end
    hold(1'b0, 1'b0, 30);

    check("dut0_pulse_count", obs_pulses[0], exp_pulses[0]);
    check("dut1_pulse_count", obs_pulses[1], exp_pulses[1]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
